// File: rtl/tanh_batch_sequencer.sv
// Batch sequencer for the tanh datapath: fetch, start LUT, interpolate, store.
// Ports: clock/reset_n, start/abort/num_samples in, busy/done out, input memory
//   read (in_addr/in_rd_en/in_data), tanh unit (ai/start_tanh/start_interpolation/
//   write_data_in), output memory write (out_addr/out_wr_en/out_data).
module tanh_batch_sequencer #(
   parameter int ADDR_W        = 10,
   parameter int LUT_LATENCY   = 1,
   parameter int INTERP_CYCLES = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_samples,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] in_addr,
   output logic              in_rd_en,
   input  logic [19:0]       in_data,
   output logic [19:0]       ai,
   output logic              start_tanh,
   output logic              start_interpolation,
   input  logic [15:0]       write_data_in,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_wr_en,
   output logic [15:0]       out_data
);

   typedef enum logic [3:0] {
      IDLE, FETCH, LOAD, TANH, LUT_WAIT, INTERP, SETTLE, WRITE, DONE
   } state_t;

   localparam logic [ADDR_W:0] ONE = 1;
   localparam logic [3:0] LUT_LAST = 4'(LUT_LATENCY - 1);
   localparam logic [3:0] INT_LAST = 4'(INTERP_CYCLES - 1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic [19:0]       ai_q, ai_d;
   logic [15:0]       odata_q, odata_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         count_q <= '0;
         wcnt_q  <= '0;
         ai_q    <= '0;
         odata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         wcnt_q  <= wcnt_d;
         ai_q    <= ai_d;
         odata_q <= odata_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      idx_d               = idx_q;
      count_d             = count_q;
      wcnt_d              = wcnt_q;
      ai_d                = ai_q;
      odata_d             = odata_q;
      busy                = (state_q != IDLE);
      done                = 1'b0;
      in_addr             = '0;
      in_rd_en            = 1'b0;
      start_tanh          = 1'b0;
      start_interpolation = 1'b0;
      out_addr            = '0;
      out_wr_en           = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               count_d = num_samples;
               idx_d   = '0;
               state_d = (num_samples == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            in_rd_en = 1'b1;
            in_addr  = idx_q[ADDR_W-1:0];
            state_d  = LOAD;
         end
         LOAD: begin
            ai_d    = in_data;
            state_d = TANH;
         end
         TANH: begin
            start_tanh = 1'b1;
            wcnt_d     = LUT_LAST;
            state_d    = LUT_WAIT;
         end
         LUT_WAIT: begin
            if (wcnt_q == '0) state_d = INTERP;
            else              wcnt_d  = wcnt_q - 4'd1;
         end
         INTERP: begin
            start_interpolation = 1'b1;
            wcnt_d              = INT_LAST;
            state_d             = SETTLE;
         end
         SETTLE: begin
            if (wcnt_q == '0) begin
               state_d = WRITE;
               odata_d = write_data_in;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         WRITE: begin
            out_wr_en = 1'b1;
            out_addr  = idx_q[ADDR_W-1:0];
            // compare against idx+1 so a full 2^ADDR_W batch never wraps
            if ((idx_q + ONE) == count_q) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + ONE;
               state_d = FETCH;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // abort wins over every transition; datapath registers are frozen
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         idx_d   = idx_q;
         wcnt_d  = wcnt_q;
         ai_d    = ai_q;
         odata_d = odata_q;
      end
   end

   assign ai       = ai_q;
   assign out_data = odata_q;

endmodule

// File: tb/tb_tanh_batch_sequencer.sv
// Scoreboard bench for tanh_batch_sequencer with memory and tanh-unit stubs.
// Expected writes/done cycles are queued by the driver and popped by a monitor.
module tb_tanh_batch_sequencer;

   localparam int AW  = 10;
   localparam int LUT = 1;
   localparam int INT = 1;

   typedef struct {
      int          addr;
      int          data;
      int          cyc;
   } wr_t;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW:0]   num_samples = '0;
   logic          busy, done, in_rd_en, start_tanh, start_interpolation, out_wr_en;
   logic [AW-1:0] in_addr, out_addr;
   logic [19:0]   in_data, ai;
   logic [15:0]   write_data_in, out_data;

   logic [19:0]   mem [0:15];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            rd_cnt = 0;
   int            wr_cnt = 0;
   int            t_tanh = 0;
   wr_t           wq[$];
   int            dq[$];

   tanh_batch_sequencer #(
      .ADDR_W(AW), .LUT_LATENCY(LUT), .INTERP_CYCLES(INT)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
      .num_samples(num_samples), .busy(busy), .done(done),
      .in_addr(in_addr), .in_rd_en(in_rd_en), .in_data(in_data),
      .ai(ai), .start_tanh(start_tanh),
      .start_interpolation(start_interpolation),
      .write_data_in(write_data_in), .out_addr(out_addr),
      .out_wr_en(out_wr_en), .out_data(out_data)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // input memory: data returns one cycle after the read strobe
   always @(posedge clock or negedge reset_n)
      if (!reset_n) in_data <= '0;
      else if (in_rd_en) in_data <= mem[in_addr[3:0]];

   // tanh stub: saturates when |ai| >= 1.0, otherwise ai[15:0]+1
   always @(posedge clock or negedge reset_n)
      if (!reset_n) write_data_in <= '0;
      else if (start_interpolation)
         write_data_in <= (ai[18:16] != 3'd0) ? 16'h7FFF : ai[15:0] + 16'd1;

   function void chk(input string n, input int a, input int e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endfunction

   // monitor
   always @(negedge clock) begin
      if (in_rd_en) rd_cnt++;
      if (start_tanh || start_interpolation)
         chk("strobe_excl", int'(start_tanh & start_interpolation), 0);
      if (start_tanh) t_tanh = cyc;
      if (start_interpolation) chk("interp_gap", cyc - t_tanh, 1 + LUT);
      if (out_wr_en) begin
         wr_cnt++;
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr %0h data %0h", out_addr, out_data);
         end else begin
            wr_t e;
            e = wq.pop_front();
            chk("wr_addr", int'(out_addr), e.addr);
            chk("wr_data", int'(out_data), e.data);
            chk("wr_cycle", cyc, e.cyc);
         end
      end
      if (done) begin
         if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got 1 expected 0 at %0d", cyc);
         end else begin
            chk("done_cycle", cyc, dq.pop_front());
         end
      end
   end

   task automatic check_reset_outs(input string n);
      chk({n, "_busy"}, int'(busy), 0);
      chk({n, "_done"}, int'(done), 0);
      chk({n, "_rd"}, int'(in_rd_en), 0);
      chk({n, "_wr"}, int'(out_wr_en), 0);
      chk({n, "_st"}, int'(start_tanh), 0);
      chk({n, "_si"}, int'(start_interpolation), 0);
      chk({n, "_ai"}, int'(ai), 0);
      chk({n, "_odata"}, int'(out_data), 0);
      chk({n, "_iaddr"}, int'(in_addr), 0);
      chk({n, "_oaddr"}, int'(out_addr), 0);
   endtask

   // drive start at a negedge; returns k = the cycle ending at the accepting edge
   task automatic kick(input int n, output int k);
      num_samples = (AW+1)'(n);
      start = 1'b1;
      k = cyc;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic drain(input string n, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (!busy && wq.size() == 0 && dq.size() == 0) begin
            ok = 1;
            break;
         end
         @(negedge clock);
      end
      chk({n, "_drain"}, int'(ok), 1);
      wq.delete();
      dq.delete();
   endtask

   initial begin
      int k, r0, w0;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      // reset
      repeat (2) @(negedge clock);
      check_reset_outs("reset");
      reset_n = 1'b1;
      @(negedge clock);

      // three samples, stub returns ai+1
      mem[0] = 20'd0; mem[1] = 20'd1; mem[2] = 20'd2;
      k = cyc;
      wq.push_back('{0, 1, k + 7});
      wq.push_back('{1, 2, k + 14});
      wq.push_back('{2, 3, k + 21});
      dq.push_back(k + 22);
      kick(3, k);
      chk("busy_k1", int'(busy), 1);
      while (cyc < k + 22) @(negedge clock);
      chk("busy_at_done", int'(busy), 1);
      @(negedge clock);
      chk("busy_fall", int'(busy), 0);
      drain("t1", 50);

      // saturating argument
      mem[0] = 20'h40000;
      k = cyc;
      wq.push_back('{0, 16'h7FFF, k + 7});
      dq.push_back(k + 8);
      kick(1, k);
      drain("t2", 50);

      // zero-length batch
      r0 = rd_cnt; w0 = wr_cnt;
      k = cyc;
      dq.push_back(k + 1);
      kick(0, k);
      drain("t3", 20);
      chk("zero_rd", rd_cnt - r0, 0);
      chk("zero_wr", wr_cnt - w0, 0);

      // abort in the second LUT_WAIT of a 4-sample batch
      mem[0] = 20'd10; mem[1] = 20'd11; mem[2] = 20'd12; mem[3] = 20'd13;
      w0 = wr_cnt;
      k = cyc;
      wq.push_back('{0, 11, k + 7});
      kick(4, k);
      while (cyc < k + 11) @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      repeat (30) @(negedge clock);
      chk("abort_writes", wr_cnt - w0, 1);
      drain("t4", 5);

      // start while busy is ignored
      mem[0] = 20'd5; mem[1] = 20'd6;
      w0 = wr_cnt;
      k = cyc;
      wq.push_back('{0, 6, k + 7});
      wq.push_back('{1, 7, k + 14});
      dq.push_back(k + 15);
      kick(2, k);
      while (cyc < k + 3) @(negedge clock);
      num_samples = (AW+1)'(9);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      drain("t5", 100);
      chk("busy_start_writes", wr_cnt - w0, 2);

      // reset during SETTLE
      mem[0] = 20'h00123; mem[1] = 20'h00456;
      kick(2, k);
      while (cyc < k + 6) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_reset_outs("midrst");
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      mem[0] = 20'd5;
      k = cyc;
      wq.push_back('{0, 6, k + 7});
      dq.push_back(k + 8);
      kick(1, k);
      drain("t6", 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
